// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH cycles with a carry flop.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder_structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;
  logic g;
  logic t;

  assign p    = a ^ b;
  assign g    = a & b;
  assign t    = p & cin;
  assign sum  = p ^ cin;
  assign cout = g | t;
endmodule

module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             carry_out_q, carry_out_d;

  logic             accept;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder_structural u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Subtraction is A + ~B + 1, so only the B operand and initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1 : carry_in;
`else
  assign b_load = op_b;
  assign c_load = carry_in;
`endif

  assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (last_bit) state_d = DONE;
        else          state_d = RUN;
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
        else              state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = (state_q == IDLE) && !reset;
    busy         = (state_q != IDLE);
    result_valid = (state_q == DONE);
    accept       = start_valid && start_ready;
  end

  always_comb begin
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    carry_d     = carry_q;
    bit_cnt_d   = bit_cnt_q;
    carry_out_d = carry_out_q;
    if ((state_q == IDLE) && accept) begin
      a_sh_d    = op_a;
      b_sh_d    = b_load;
      carry_d   = c_load;
      bit_cnt_d = {CW{1'b0}};
    end else if (state_q == RUN) begin
      a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
      res_sh_d  = {fa_sum, res_sh_q[WIDTH-1:1]};
      carry_d   = fa_cout;
      bit_cnt_d = bit_cnt_q + CW'(1);
      if (last_bit) carry_out_d = fa_cout;
      else          carry_out_d = carry_out_q;
    end else begin
      carry_out_d = carry_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_q      <= {WIDTH{1'b0}};
      b_sh_q      <= {WIDTH{1'b0}};
      res_sh_q    <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      bit_cnt_q   <= {CW{1'b0}};
      carry_out_q <= 1'b0;
    end else begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      carry_q     <= carry_d;
      bit_cnt_q   <= bit_cnt_d;
      carry_out_q <= carry_out_d;
    end
  end

  // res_sh only moves in RUN, so it holds the last completed sum in DONE and IDLE.
  assign result    = res_sh_q;
  assign carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_adder_controller.sv
// Scoreboard bench for serial_adder_controller (WIDTH=8 instance plus a WIDTH=2 instance).
// Subtract scenarios run only when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_controller;
  localparam int W = 8;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic [W-1:0] result;
  logic         carry_out;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic         busy;

  logic         start_valid2 = 1'b0;
  logic         start_ready2;
  logic [1:0]   op_a2 = '0;
  logic [1:0]   op_b2 = '0;
  logic         carry_in2 = 1'b0;
  logic [1:0]   result2;
  logic         carry_out2;
  logic         result_valid2;
  logic         result_ready2 = 1'b1;
  logic         busy2;

  logic [W:0] exp_q[$];
  logic [2:0] exp2_q[$];

  serial_adder_controller #(.WIDTH(W)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .carry_in     (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub          (sub),
`endif
    .result       (result),
    .carry_out    (carry_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  serial_adder_controller #(.WIDTH(2)) u_dut2 (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid2),
    .start_ready  (start_ready2),
    .op_a         (op_a2),
    .op_b         (op_b2),
    .carry_in     (carry_in2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub          (1'b0),
`endif
    .result       (result2),
    .carry_out    (carry_out2),
    .result_valid (result_valid2),
    .result_ready (result_ready2),
    .busy         (busy2)
  );

  // Pushes the expected value, then presents the operands for exactly one edge.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s);
    logic [W:0] e;
    if (s) e = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   e = {1'b0, a} + {1'b0, b} + {8'd0, c};
    exp_q.push_back(e);
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready got=%b exp=1", start_ready);
    end
    op_a = a; op_b = b; carry_in = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); carry_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 4 * W) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_run got=%b exp=1 at_edge=%0d", busy, lat);
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL result_valid_timeout got=%b exp=1", result_valid);
    end
  endtask

  task automatic finish_op(input string name);
    logic [W:0] e;
    e = '0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard_empty got=0 exp=1", name);
    end else begin
      e = exp_q.pop_front();
      if ({carry_out, result} !== e) begin
        failures++;
        $display("FAIL %s_result got=%h exp=%h", name, {carry_out, result}, e);
      end
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release got=v%b b%b r%b exp=v0 b0 r1", name, result_valid, busy, start_ready);
    end
    checks++;
    if ({carry_out, result} !== e) begin
      failures++;
      $display("FAIL %s_hold_idle got=%h exp=%h", name, {carry_out, result}, e);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (start_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 ||
        result !== 8'h00 || carry_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=r%b b%b v%b res=%h c=%b exp=r0 b0 v0 res=00 c=0",
               start_ready, busy, result_valid, result, carry_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", start_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [W-1:0] r;
    accept_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != W) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, W);
    end
    r = result;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b1 || result !== r) begin
        failures++;
        $display("FAIL basic_hold got=v%b b%b res=%h exp=v1 b1 res=%h", result_valid, busy, result, r);
      end
    end
    finish_op("basic");
  endtask

  task automatic test_carry;
    int lat;
    logic [W-1:0] a_t[4] = '{8'hFF, 8'hFF, 8'h80, 8'h00};
    logic [W-1:0] b_t[4] = '{8'h01, 8'hFF, 8'h80, 8'h00};
    logic         c_t[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      accept_op(a_t[i], b_t[i], c_t[i], 1'b0);
      wait_done(lat);
      finish_op("carry");
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    for (int i = 0; i < 6; i++) begin
      accept_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      wait_done(lat);
      finish_op("b2b");
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [W-1:0] r;
    accept_op(8'h12, 8'h34, 1'b1, 1'b0);
    wait_done(lat);
    r = result;
    for (int i = 0; i < 5; i++) begin
      op_a = 8'($urandom); op_b = 8'($urandom); carry_in = 1'($urandom);
      start_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || result !== r || start_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold got=v%b res=%h r%b exp=v1 res=%h r0", result_valid, result, start_ready, r);
      end
    end
    start_valid = 1'b0;
    finish_op("bp");
    accept_op(8'hA0, 8'h0B, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_accept got=%b exp=1", busy);
    end
    wait_done(lat);
    finish_op("bp_next");
  endtask

  task automatic test_mid_reset;
    logic [W:0] dropped;
    accept_op(8'h77, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dropped = exp_q.pop_back();
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 8'h00 ||
        carry_out !== 1'b0 || start_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got=b%b v%b res=%h c=%b r%b exp=b0 v0 res=00 c=0 r0 (dropped %h)",
               busy, result_valid, result, carry_out, start_ready, dropped);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got=%b exp=1", start_ready);
    end
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL midreset_stray got=v%b b%b exp=v0 b0", result_valid, busy);
      end
    end
  endtask

  task automatic test_reset_start;
    reset = 1'b1;
    start_valid = 1'b1;
    op_a = 8'h01; op_b = 8'h01;
    @(negedge clk);
    reset = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins got=b%b v%b exp=b0 v0", busy, result_valid);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat;
    accept_op(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done(lat);
    finish_op("sub_nb");
    accept_op(8'h01, 8'h02, 1'b0, 1'b1);
    wait_done(lat);
    finish_op("sub_borrow");
    accept_op(8'h10, 8'h01, 1'b1, 1'b1);
    wait_done(lat);
    finish_op("sub_cin_ign");
    accept_op(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done(lat);
    finish_op("sub_cin_ign2");
  endtask
`endif

  task automatic test_exhaustive_w2;
    int lat;
    logic [2:0] e;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp2_q.push_back(3'(a + b + c));
          checks++;
          if (start_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL w2_ready got=%b exp=1", start_ready2);
          end
          op_a2 = 2'(a); op_b2 = 2'(b); carry_in2 = 1'(c);
          start_valid2 = 1'b1;
          @(negedge clk);
          start_valid2 = 1'b0;
          op_a2 = 2'($urandom); op_b2 = 2'($urandom);
          lat = 0;
          while (result_valid2 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
          end
          e = exp2_q.pop_front();
          checks++;
          if (result_valid2 !== 1'b1 || lat != 2 || {carry_out2, result2} !== e) begin
            failures++;
            $display("FAIL w2_sum a=%0d b=%0d c=%0d got=%h lat=%0d exp=%h lat=2",
                     a, b, c, {carry_out2, result2}, lat, e);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_reset_start();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_exhaustive_w2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
